fsm3_dir_decoder: RTL and testbench

Receive-side inverse of the ex6.2.3 mod-4 reversible counter FSM. The decoder watches the counter's 2-bit state sequence and recovers the direction input A for each step. It also regenerates the carry/borrow output and keeps a net position count. Illegal state steps are flagged, and a lock state machine reports whether the observed stream is trustworthy.

---
 rtl/fsm3_dir_decoder.sv | 129 ++++++++++++
 tb/tb_fsm3_dir_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm3_dir_decoder.sv
// Receive-side decoder for a mod-4 up/down counter: recovers the step direction,
// the carry/borrow, a net position and illegal-step statistics from the observed state stream.
module fsm3_dir_decoder #(
    parameter int POS_W  = 8,
    parameter int ERR_W  = 4,
    parameter int LOCK_N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [1:0]       state_in,
    output logic             dir_valid,
    output logic             dir,
    output logic             carry,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [POS_W-1:0] pos_cnt,
    output logic             locked
);

    // state  | meaning
    // IDLE   | no reference sample captured yet
    // TRACK  | reference held, fewer than LOCK_N consecutive legal steps
    // LOCKED | at least LOCK_N consecutive legal steps observed
    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    localparam logic [3:0] RUN_MAX = 4'(LOCK_N);

    state_t             state_q, state_d;
    logic [1:0]         prev_q, prev_d;
    logic [3:0]         run_q, run_d;
    logic               dir_valid_q, dir_valid_d;
    logic               dir_q, dir_d;
    logic               carry_q, carry_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [POS_W-1:0]   pos_cnt_q, pos_cnt_d;
    logic               locked_q, locked_d;
    logic [1:0]         delta;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        run_d       = run_q;
        dir_valid_d = 1'b0;
        dir_d       = 1'b0;
        carry_d     = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        pos_cnt_d   = pos_cnt_q;
        delta       = state_in - prev_q;

        if (clr) begin
            state_d   = IDLE;
            prev_d    = 2'b00;
            run_d     = 4'd0;
            err_cnt_d = '0;
            pos_cnt_d = '0;
        end else if (in_valid) begin
            // Every processed sample becomes the new reference, legal or not.
            prev_d = state_in;
            if (state_q == IDLE) begin
                state_d = TRACK;
            end else begin
                case (delta)
                    2'b01: begin
                        dir_valid_d = 1'b1;
                        carry_d     = (prev_q == 2'b11);
                        pos_cnt_d   = pos_cnt_q + 1'b1;
                    end
                    2'b11: begin
                        dir_valid_d = 1'b1;
                        dir_d       = 1'b1;
                        carry_d     = (prev_q == 2'b00);
                        pos_cnt_d   = pos_cnt_q - 1'b1;
                    end
                    default: begin
                        err_d   = 1'b1;
                        run_d   = 4'd0;
                        state_d = TRACK;
                        if (err_cnt_q != '1)
                            err_cnt_d = err_cnt_q + 1'b1;
                    end
                endcase
                if (dir_valid_d) begin
                    run_d   = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 4'd1;
                    state_d = (run_d == RUN_MAX) ? LOCKED : TRACK;
                end
            end
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prev_q      <= 2'b00;
            run_q       <= 4'd0;
            dir_valid_q <= 1'b0;
            dir_q       <= 1'b0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            pos_cnt_q   <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            dir_valid_q <= dir_valid_d;
            dir_q       <= dir_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            pos_cnt_q   <= pos_cnt_d;
            locked_q    <= locked_d;
        end
    end

    assign dir_valid = dir_valid_q;
    assign dir       = dir_q;
    assign carry     = carry_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign pos_cnt   = pos_cnt_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_fsm3_dir_decoder.sv
// Bench for fsm3_dir_decoder: directed scenarios plus a randomized stream, all checked
// against a step-rule model of the decoder kept in plain integers.
module tb_fsm3_dir_decoder;

    localparam int POS_W  = 8;
    localparam int ERR_W  = 2;
    localparam int LOCK_N = 4;

    logic             clk = 1'b0;
    logic             reset, clr, in_valid;
    logic [1:0]       state_in;
    logic             dir_valid, dir, carry, err, locked;
    logic [ERR_W-1:0] err_cnt;
    logic [POS_W-1:0] pos_cnt;

    fsm3_dir_decoder #(.POS_W(POS_W), .ERR_W(ERR_W), .LOCK_N(LOCK_N)) dut (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .state_in(state_in),
        .dir_valid(dir_valid), .dir(dir), .carry(carry), .err(err),
        .err_cnt(err_cnt), .pos_cnt(pos_cnt), .locked(locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the decoder described by its step rules only.
    bit m_ref;
    int m_prev, m_run, m_pos, m_errc;
    bit e_dv, e_dir, e_carry, e_err;

    function automatic void model_clear();
        m_ref = 0; m_prev = 0; m_run = 0; m_pos = 0; m_errc = 0;
        e_dv = 0; e_dir = 0; e_carry = 0; e_err = 0;
    endfunction

    function automatic void model_step(bit v, int s, bit c);
        int d;
        e_dv = 0; e_dir = 0; e_carry = 0; e_err = 0;
        if (c) begin
            model_clear();
        end else if (v) begin
            if (!m_ref) begin
                m_ref = 1;
            end else begin
                d = (s - m_prev + 4) % 4;
                if (d == 1 || d == 3) begin
                    e_dv    = 1;
                    e_dir   = (d == 3);
                    e_carry = (d == 1) ? (m_prev == 3) : (m_prev == 0);
                    m_pos   = (d == 1) ? m_pos + 1 : m_pos - 1;
                    m_run   = (m_run + 1 > LOCK_N) ? LOCK_N : m_run + 1;
                end else begin
                    e_err  = 1;
                    m_run  = 0;
                    m_errc = (m_errc + 1 > (1 << ERR_W) - 1) ? (1 << ERR_W) - 1 : m_errc + 1;
                end
            end
            m_prev = s;
        end
    endfunction

    function automatic logic [13:0] exp_vec();
        logic [7:0] p;
        logic [1:0] e;
        p = 8'(m_pos);
        e = 2'(m_errc);
        return {e_dv, e_carry, e_err, 1'(m_run >= LOCK_N), p, e};
    endfunction

    function automatic logic [13:0] act_vec();
        return {dir_valid, carry, err, locked, pos_cnt, err_cnt};
    endfunction

    task automatic apply(bit v, logic [1:0] s, bit c);
        in_valid = v; state_in = s; clr = c;
        @(posedge clk);
        #1;
        model_step(v, int'(s), c);
        in_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; clr = 1'b0; state_in = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; clr = 1'b0; state_in = 2'b00;
        #12;
        checks++;
        if ({act_vec(), dir} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0", {act_vec(), dir});
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_up();
        logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, seq[i], 1'b0);
            checks++;
            if (act_vec() !== exp_vec() || (e_dv && dir !== e_dir)) begin
                errors++;
                $display("FAIL up_step%0d got %h/%b expected %h/%b", i, act_vec(), dir, exp_vec(), e_dir);
            end
        end
        checks++;
        if (pos_cnt !== 8'd4 || locked !== 1'b1 || err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL up_final got pos %h lock %b errc %h expected 04 1 0", pos_cnt, locked, err_cnt);
        end
    endtask

    task automatic test_down();
        logic [1:0] seq [3] = '{2'd0, 2'd3, 2'd2};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, seq[i], 1'b0);
            checks++;
            if (act_vec() !== exp_vec() || (e_dv && dir !== e_dir)) begin
                errors++;
                $display("FAIL down_step%0d got %h/%b expected %h/%b", i, act_vec(), dir, exp_vec(), e_dir);
            end
        end
        checks++;
        if (pos_cnt !== 8'hFE || locked !== 1'b0) begin
            errors++;
            $display("FAIL down_final got pos %h lock %b expected fe 0", pos_cnt, locked);
        end
    endtask

    task automatic test_illegal_relock();
        logic [1:0] seq [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, seq[i], 1'b0);
            checks++;
            if (act_vec() !== exp_vec() || (e_dv && dir !== e_dir)) begin
                errors++;
                $display("FAIL illegal_step%0d got %h/%b expected %h/%b", i, act_vec(), dir, exp_vec(), e_dir);
            end
            if (i == 5) begin
                checks++;
                if (err !== 1'b1 || locked !== 1'b0 || pos_cnt !== 8'd4 || err_cnt !== 2'd1) begin
                    errors++;
                    $display("FAIL illegal_hit got err %b lock %b pos %h errc %h expected 1 0 04 1",
                             err, locked, pos_cnt, err_cnt);
                end
            end
        end
        checks++;
        if (dir_valid !== 1'b1 || dir !== 1'b0 || pos_cnt !== 8'd5 || err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_recover got dv %b dir %b pos %h err %b expected 1 0 05 0",
                     dir_valid, dir, pos_cnt, err);
        end
    endtask

    task automatic test_err_saturation();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 2'd1, 1'b0);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL sat_step%0d got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        apply(1'b0, 2'd1, 1'b0);
        checks++;
        if (err_cnt !== 2'b11 || err !== 1'b0 || dir_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_final got errc %b err %b dv %b expected 11 0 0", err_cnt, err, dir_valid);
        end
    endtask

    task automatic test_clr();
        logic [1:0] seq [3] = '{2'd0, 2'd1, 2'd2};
        do_reset();
        for (int i = 0; i < 3; i++) apply(1'b1, seq[i], 1'b0);
        apply(1'b1, 2'd2, 1'b1);
        checks++;
        if ({act_vec(), dir} !== 15'h0) begin
            errors++;
            $display("FAIL clr_outputs got %h expected 0", {act_vec(), dir});
        end
        apply(1'b1, 2'd3, 1'b0);
        checks++;
        if (act_vec() !== exp_vec() || dir_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL clr_reference got %h expected %h", act_vec(), exp_vec());
        end
        apply(1'b1, 2'd0, 1'b0);
        checks++;
        if (act_vec() !== exp_vec() || pos_cnt !== 8'd1 || carry !== 1'b1) begin
            errors++;
            $display("FAIL clr_first_step got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
        do_reset();
        for (int i = 0; i < 6; i++) apply(1'b1, seq[i], 1'b0);
        checks++;
        if (locked !== 1'b1 || pos_cnt !== 8'd3) begin
            errors++;
            $display("FAIL async_setup got lock %b pos %h expected 1 03", locked, pos_cnt);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (locked !== 1'b0 || pos_cnt !== 8'd0 || err_cnt !== 2'd0 || clk !== 1'b1) begin
            errors++;
            $display("FAIL async_clear got lock %b pos %h errc %h expected 0 00 0", locked, pos_cnt, err_cnt);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] last, s;
        bit v, c;
        int r;
        do_reset();
        last = 2'd0;
        for (int i = 0; i < 500; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 40) == 0);
            r = $urandom_range(0, 9);
            s = (r < 4) ? last + 2'd1 : (r < 7) ? last - 2'd1 : 2'($urandom_range(0, 3));
            if (v) last = s;
            apply(v, s, c);
            checks++;
            if (act_vec() !== exp_vec() || (e_dv && dir !== e_dir)) begin
                errors++;
                $display("FAIL random_cyc%0d got %h/%b expected %h/%b", i, act_vec(), dir, exp_vec(), e_dir);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_up();
        test_down();
        test_illegal_relock();
        test_err_saturation();
        test_clr();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
